// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: T-state control FSM driving the single-bus CPU datapath.
// Build option SINGLE_STEP_EN adds a Step input and pauses after each instruction.
module ctrl_sequencer #(
  parameter int unsigned MEM_WAIT = 0,
  parameter logic [4:0]  ALU_ADD  = 5'd3
) (
  input  logic        Clock,
  input  logic        Clear,
  input  logic [31:0] IR,
  input  logic        CON,
  input  logic        Stop,
`ifdef SINGLE_STEP_EN
  input  logic        Step,
`endif
  output logic        PCout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        InPortout,
  output logic        Cout,
  output logic        Rout,
  output logic        BAout,
  output logic        Zhiout,
  output logic        HIout,
  output logic        LOout,
  output logic        HIin,
  output logic        LOin,
  output logic        MARin,
  output logic        Zin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        OutPortin,
  output logic        Rin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic        CONIn,
  output logic [4:0]  alu_op,
  output logic        Run
);

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3,
    S_T4, S_T5, S_T6, S_T7,
    S_HALT, S_STOP, S_PAUSE
  } state_t;

  typedef struct packed {
    logic pc_out, zlo_out, mdr_out, inp_out;
    logic c_out, r_out, ba_out;
    logic mar_in, z_in, pc_in, mdr_in;
    logic ir_in, y_in, outp_in, r_in;
    logic gra, grb, grc, inc_pc;
    logic rd, wr, con_in;
    logic [4:0] alu;
    logic run;
  } ctl_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [2:0] LP_MW = 3'(MEM_WAIT);

  state_t     r_state;
  state_t     w_nxt;
  state_t     w_done;
  logic [4:0] r_op;
  logic [4:0] w_op;
  logic       r_con;
  logic [2:0] r_wcnt;
  logic [2:0] w_wcnt;
  ctl_t       r_ctl;
  ctl_t       w_ctl;
  logic       w_alu, w_imm, w_ld, w_st, w_mem;
  logic       w_br, w_in, w_out, w_halt, w_ba;
  logic       w_unused_ir;

  assign w_unused_ir = ^IR[26:0];

  // T3 outputs are decoded during T2, before r_op holds the new opcode
  assign w_op = (r_state == S_T2) ? IR[31:27] : r_op;

  always_comb begin
    w_alu  = (w_op == OP_ADD) | (w_op == OP_SUB) |
             (w_op == OP_AND) | (w_op == OP_OR);
    w_imm  = (w_op == OP_ADDI) | (w_op == OP_LDI);
    w_ld   = (w_op == OP_LD);
    w_st   = (w_op == OP_ST);
    w_mem  = w_ld | w_st;
    w_br   = (w_op == OP_BR);
    w_in   = (w_op == OP_IN);
    w_out  = (w_op == OP_OUT);
    w_halt = (w_op == OP_HALT);
    w_ba   = w_mem | (w_op == OP_LDI);
  end

`ifdef SINGLE_STEP_EN
  logic r_step;
  logic w_step_rise;

  assign w_step_rise = Step & ~r_step;
  assign w_done = Stop ? S_STOP : S_PAUSE;

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) r_step <= 1'b0;
    else        r_step <= Step;
  end
`else
  assign w_done = Stop ? S_STOP : S_T0;
`endif

  always_comb begin
    w_nxt  = r_state;
    w_wcnt = r_wcnt;
    unique case (r_state)
      S_RESET: w_nxt = S_T0;
      S_T0: begin
        w_nxt  = S_T1;
        w_wcnt = LP_MW;
      end
      S_T1: begin
        if (r_wcnt != 3'd0) w_wcnt = r_wcnt - 3'd1;
        else                w_nxt  = S_T2;
      end
      S_T2: w_nxt = S_T3;
      S_T3: begin
        if (w_halt)
          w_nxt = S_HALT;
        else if (w_alu | w_imm | w_mem | w_br)
          w_nxt = S_T4;
        else
          w_nxt = w_done;
      end
      S_T4: w_nxt = S_T5;
      S_T5: begin
        if (w_alu | w_imm) begin
          w_nxt = w_done;
        end else begin
          w_nxt  = S_T6;
          w_wcnt = LP_MW;
        end
      end
      S_T6: begin
        if (w_ld && r_wcnt != 3'd0) w_wcnt = r_wcnt - 3'd1;
        else if (w_br)              w_nxt  = w_done;
        else                        w_nxt  = S_T7;
      end
      S_T7:   w_nxt = w_done;
      S_HALT: w_nxt = S_HALT;
      S_STOP: if (!Stop) w_nxt = S_T0;
`ifdef SINGLE_STEP_EN
      S_PAUSE: if (w_step_rise) w_nxt = S_T0;
`else
      S_PAUSE: w_nxt = S_T0;
`endif
      default: w_nxt = S_RESET;
    endcase
  end

  always_comb begin
    w_ctl = '0;
    unique case (w_nxt)
      S_T0: begin
        w_ctl.pc_out = 1'b1;
        w_ctl.mar_in = 1'b1;
        w_ctl.inc_pc = 1'b1;
      end
      S_T1: begin
        w_ctl.rd     = 1'b1;
        w_ctl.mdr_in = 1'b1;
      end
      S_T2: begin
        w_ctl.mdr_out = 1'b1;
        w_ctl.ir_in   = 1'b1;
      end
      S_T3: begin
        unique case (1'b1)
          w_alu | w_imm | w_mem: begin
            w_ctl.grb    = 1'b1;
            w_ctl.y_in   = 1'b1;
            w_ctl.r_out  = ~w_ba;
            w_ctl.ba_out = w_ba;
          end
          w_br: begin
            w_ctl.gra    = 1'b1;
            w_ctl.r_out  = 1'b1;
            w_ctl.con_in = 1'b1;
          end
          w_in: begin
            w_ctl.inp_out = 1'b1;
            w_ctl.gra     = 1'b1;
            w_ctl.r_in    = 1'b1;
          end
          w_out: begin
            w_ctl.gra     = 1'b1;
            w_ctl.r_out   = 1'b1;
            w_ctl.outp_in = 1'b1;
          end
          default: ;
        endcase
      end
      S_T4: begin
        unique case (1'b1)
          w_alu: begin
            w_ctl.grc   = 1'b1;
            w_ctl.r_out = 1'b1;
            w_ctl.z_in  = 1'b1;
            w_ctl.alu   = w_op;
          end
          w_imm | w_mem: begin
            w_ctl.c_out = 1'b1;
            w_ctl.z_in  = 1'b1;
            w_ctl.alu   = ALU_ADD;
          end
          w_br: begin
            w_ctl.pc_out = 1'b1;
            w_ctl.y_in   = 1'b1;
          end
          default: ;
        endcase
      end
      S_T5: begin
        unique case (1'b1)
          w_alu | w_imm: begin
            w_ctl.zlo_out = 1'b1;
            w_ctl.gra     = 1'b1;
            w_ctl.r_in    = 1'b1;
          end
          w_mem: begin
            w_ctl.zlo_out = 1'b1;
            w_ctl.mar_in  = 1'b1;
          end
          w_br: begin
            w_ctl.c_out = 1'b1;
            w_ctl.z_in  = 1'b1;
            w_ctl.alu   = ALU_ADD;
          end
          default: ;
        endcase
      end
      S_T6: begin
        unique case (1'b1)
          w_ld: begin
            w_ctl.rd     = 1'b1;
            w_ctl.mdr_in = 1'b1;
          end
          w_st: begin
            w_ctl.gra    = 1'b1;
            w_ctl.r_out  = 1'b1;
            w_ctl.mdr_in = 1'b1;
          end
          w_br: begin
            w_ctl.zlo_out = r_con;
            w_ctl.pc_in   = r_con;
          end
          default: ;
        endcase
      end
      S_T7: begin
        w_ctl.mdr_out = w_ld;
        w_ctl.gra     = w_ld;
        w_ctl.r_in    = w_ld;
        w_ctl.wr      = w_st;
      end
      default: ;
    endcase
    w_ctl.run = !(w_nxt inside {S_RESET, S_HALT, S_STOP, S_PAUSE});
  end

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      r_state <= S_RESET;
      r_ctl   <= '0;
      r_wcnt  <= '0;
      r_op    <= '0;
      r_con   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_ctl   <= w_ctl;
      r_wcnt  <= w_wcnt;
      if (r_state == S_T2) r_op  <= IR[31:27];
      if (r_state == S_T4) r_con <= CON;
    end
  end

  assign PCout     = r_ctl.pc_out;
  assign Zlowout   = r_ctl.zlo_out;
  assign MDRout    = r_ctl.mdr_out;
  assign InPortout = r_ctl.inp_out;
  assign Cout      = r_ctl.c_out;
  assign Rout      = r_ctl.r_out;
  assign BAout     = r_ctl.ba_out;
  assign Zhiout    = 1'b0;
  assign HIout     = 1'b0;
  assign LOout     = 1'b0;
  assign HIin      = 1'b0;
  assign LOin      = 1'b0;
  assign MARin     = r_ctl.mar_in;
  assign Zin       = r_ctl.z_in;
  assign PCin      = r_ctl.pc_in;
  assign MDRin     = r_ctl.mdr_in;
  assign IRin      = r_ctl.ir_in;
  assign Yin       = r_ctl.y_in;
  assign OutPortin = r_ctl.outp_in;
  assign Rin       = r_ctl.r_in;
  assign Gra       = r_ctl.gra;
  assign Grb       = r_ctl.grb;
  assign Grc       = r_ctl.grc;
  assign IncPC     = r_ctl.inc_pc;
  assign Read      = r_ctl.rd;
  assign Write     = r_ctl.wr;
  assign CONIn     = r_ctl.con_in;
  assign alu_op    = r_ctl.alu;
  assign Run       = r_ctl.run;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb_ctrl_sequencer: two sequencers (MEM_WAIT 0 and 2) checked cycle by
// cycle against a table of per-opcode T-state strobe sets.
`timescale 1ns/1ps
module tb_ctrl_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clr;
  logic [31:0] ir_s   [2];
  logic        con_s  [2];
  logic        stop_s [2];
  logic [32:0] obs    [2];

  int total = 0;
  int bad   = 0;
  logic [32:0] exp_q [$];

  localparam logic [31:0] NOP_IR = 32'hD000_0000;
  localparam logic [4:0]  ADDOP  = 5'd3;

  // strobe bit positions in obs[26:0]
  localparam logic [26:0] M_PCO   = 27'b1 << 0;
  localparam logic [26:0] M_ZLO   = 27'b1 << 1;
  localparam logic [26:0] M_MDRO  = 27'b1 << 2;
  localparam logic [26:0] M_INPO  = 27'b1 << 3;
  localparam logic [26:0] M_CO    = 27'b1 << 4;
  localparam logic [26:0] M_RO    = 27'b1 << 5;
  localparam logic [26:0] M_BAO   = 27'b1 << 6;
  localparam logic [26:0] M_MARI  = 27'b1 << 12;
  localparam logic [26:0] M_ZI    = 27'b1 << 13;
  localparam logic [26:0] M_PCI   = 27'b1 << 14;
  localparam logic [26:0] M_MDRI  = 27'b1 << 15;
  localparam logic [26:0] M_IRI   = 27'b1 << 16;
  localparam logic [26:0] M_YI    = 27'b1 << 17;
  localparam logic [26:0] M_OUTPI = 27'b1 << 18;
  localparam logic [26:0] M_RI    = 27'b1 << 19;
  localparam logic [26:0] M_GRA   = 27'b1 << 20;
  localparam logic [26:0] M_GRB   = 27'b1 << 21;
  localparam logic [26:0] M_GRC   = 27'b1 << 22;
  localparam logic [26:0] M_INC   = 27'b1 << 23;
  localparam logic [26:0] M_RD    = 27'b1 << 24;
  localparam logic [26:0] M_WR    = 27'b1 << 25;
  localparam logic [26:0] M_CONI  = 27'b1 << 26;
  localparam logic [32:0] DRV     = 33'h3FF;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic pco, zlo, mdro, inpo, co, ro, bao;
    logic zhio, hio, loo, hii, loi;
    logic mari, zi, pci, mdri, iri, yi, outpi, ri;
    logic gra, grb, grc, inc, rd, wr, coni, run;
    logic [4:0] alu;

    ctrl_sequencer #(.MEM_WAIT(g * 2)) u_dut (
      .Clock(clk), .Clear(clr), .IR(ir_s[g]),
      .CON(con_s[g]), .Stop(stop_s[g]),
`ifdef SINGLE_STEP_EN
      .Step(1'b0),
`endif
      .PCout(pco), .Zlowout(zlo), .MDRout(mdro),
      .InPortout(inpo), .Cout(co), .Rout(ro),
      .BAout(bao), .Zhiout(zhio), .HIout(hio),
      .LOout(loo), .HIin(hii), .LOin(loi),
      .MARin(mari), .Zin(zi), .PCin(pci),
      .MDRin(mdri), .IRin(iri), .Yin(yi),
      .OutPortin(outpi), .Rin(ri), .Gra(gra),
      .Grb(grb), .Grc(grc), .IncPC(inc),
      .Read(rd), .Write(wr), .CONIn(coni),
      .alu_op(alu), .Run(run)
    );

    assign obs[g] = {run, alu, coni, wr, rd, inc,
                     grc, grb, gra, ri, outpi, yi,
                     iri, mdri, pci, zi, mari,
                     loi, hii, loo, hio, zhio,
                     bao, ro, co, inpo, mdro, zlo, pco};
  end

  function automatic void push(input logic [26:0] s,
                               input logic [4:0] a,
                               input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({1'b1, a, s});
  endfunction

  // per-opcode T-state table: fetch, then execute steps
  function automatic void model(input logic [4:0] op,
                                input int mw, input bit con);
    push(M_PCO | M_MARI | M_INC, 5'd0, 1);
    push(M_RD | M_MDRI, 5'd0, mw + 1);
    push(M_MDRO | M_IRI, 5'd0, 1);
    case (op)
      5'd3, 5'd4, 5'd5, 5'd6: begin
        push(M_GRB | M_RO | M_YI, 5'd0, 1);
        push(M_GRC | M_RO | M_ZI, op, 1);
        push(M_ZLO | M_GRA | M_RI, 5'd0, 1);
      end
      5'd12, 5'd1: begin
        push(M_GRB | ((op == 5'd1) ? M_BAO : M_RO) | M_YI, 5'd0, 1);
        push(M_CO | M_ZI, ADDOP, 1);
        push(M_ZLO | M_GRA | M_RI, 5'd0, 1);
      end
      5'd0, 5'd2: begin
        push(M_GRB | M_BAO | M_YI, 5'd0, 1);
        push(M_CO | M_ZI, ADDOP, 1);
        push(M_ZLO | M_MARI, 5'd0, 1);
        if (op == 5'd0) begin
          push(M_RD | M_MDRI, 5'd0, mw + 1);
          push(M_MDRO | M_GRA | M_RI, 5'd0, 1);
        end else begin
          push(M_GRA | M_RO | M_MDRI, 5'd0, 1);
          push(M_WR, 5'd0, 1);
        end
      end
      5'd18: begin
        push(M_GRA | M_RO | M_CONI, 5'd0, 1);
        push(M_PCO | M_YI, 5'd0, 1);
        push(M_CO | M_ZI, ADDOP, 1);
        push(con ? (M_ZLO | M_PCI) : 27'd0, 5'd0, 1);
      end
      5'd22: push(M_INPO | M_GRA | M_RI, 5'd0, 1);
      5'd23: push(M_GRA | M_RO | M_OUTPI, 5'd0, 1);
      default: push(27'd0, 5'd0, 1);
    endcase
  endfunction

  // both DUTs to RESET; next rising edge puts them in T0
  task automatic resync();
    @(negedge clk);
    clr = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ir_s[i]   = NOP_IR;
      con_s[i]  = 1'b0;
      stop_s[i] = 1'b0;
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      total++;
      if (obs[i] !== 33'd0) begin
        bad++;
        $display("FAIL clear_zero dut%0d got=%h exp=0", i, obs[i]);
      end
    end
    @(negedge clk);
    clr = 1'b1;
  endtask

  task automatic check_idle(input int d, input int n, input string nm);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      total++;
      if (obs[d] !== 33'd0) begin
        bad++;
        $display("FAIL %s dut%0d cyc=%0d got=%h exp=0",
                 nm, d, k, obs[d]);
      end
    end
  endtask

  task automatic run_instr(input int d, input logic [31:0] ir,
                           input bit con, input bit stp,
                           input int abort_at);
    int mw, fl, n;
    bit aborted;
    logic [32:0] e;
    logic [4:0] op;
    mw = (d == 0) ? 0 : 2;
    fl = mw + 3;
    op = ir[31:27];
    aborted = 1'b0;
    exp_q.delete();
    model(op, mw, con);
    n = exp_q.size();
    ir_s[d]  = ir;
    con_s[d] = con;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      e = exp_q[k];
      total++;
      if (obs[d] !== e) begin
        bad++;
        $display("FAIL step dut%0d op=%b k=%0d got=%h exp=%h",
                 d, op, k, obs[d], e);
      end
      total++;
      if ($countones(obs[d] & DRV) > 1) begin
        bad++;
        $display("FAIL bus_onehot dut%0d k=%0d got=%h exp=<=1 drive",
                 d, k, obs[d]);
      end
      if (k == 0) stop_s[d] = stp;
      if (k == fl) ir_s[d] = $urandom;
      if (k == fl + 2) con_s[d] = ~con;
      if (k == abort_at) begin
        clr = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
          total++;
          if (obs[i] !== 33'd0) begin
            bad++;
            $display("FAIL abort_zero dut%0d got=%h exp=0", i, obs[i]);
          end
        end
        @(negedge clk);
        clr = 1'b1;
        stop_s[d] = 1'b0;
        aborted = 1'b1;
        break;
      end
    end
    if (!aborted && stp) begin
      check_idle(d, 3, "stopped");
      stop_s[d] = 1'b0;
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op);
    logic [26:0] f;
    f = 27'($urandom);
    return {op, f};
  endfunction

  task automatic test_reset();
    resync();
    run_instr(0, mk(5'd3), 1'b0, 1'b0, -1);
  endtask

  task automatic test_alu();
    for (int d = 0; d < 2; d++) begin
      resync();
      for (int o = 3; o <= 6; o++)
        run_instr(d, mk(5'(o)), 1'($urandom), 1'b0, -1);
    end
  endtask

  task automatic test_imm_io();
    logic [4:0] ops [6];
    ops = '{5'd12, 5'd1, 5'd22, 5'd23, 5'd26, 5'd31};
    for (int d = 0; d < 2; d++) begin
      resync();
      for (int i = 0; i < 6; i++)
        run_instr(d, mk(ops[i]), 1'b1, 1'b0, -1);
    end
  endtask

  task automatic test_ld_st();
    for (int d = 0; d < 2; d++) begin
      resync();
      run_instr(d, mk(5'd0), 1'b0, 1'b0, -1);
      run_instr(d, mk(5'd2), 1'b1, 1'b0, -1);
      run_instr(d, mk(5'd0), 1'b1, 1'b0, -1);
    end
  endtask

  task automatic test_br();
    for (int d = 0; d < 2; d++) begin
      resync();
      run_instr(d, mk(5'd18), 1'b1, 1'b0, -1);
      run_instr(d, mk(5'd18), 1'b0, 1'b0, -1);
    end
  endtask

  task automatic test_clear_mid();
    for (int d = 0; d < 2; d++) begin
      resync();
      run_instr(d, mk(5'd3), 1'b0, 1'b0, (d == 0) ? 4 : 6);
      run_instr(d, mk(5'd4), 1'b0, 1'b0, -1);
    end
  endtask

  task automatic test_stop();
    for (int d = 0; d < 2; d++) begin
      resync();
      run_instr(d, mk(5'd3), 1'b0, 1'b1, -1);
      run_instr(d, mk(5'd6), 1'b0, 1'b0, -1);
    end
  endtask

  task automatic test_halt();
    for (int d = 0; d < 2; d++) begin
      resync();
      run_instr(d, mk(5'd27), 1'b0, 1'b0, -1);
      check_idle(d, 20, "halted");
    end
    resync();
    run_instr(0, mk(5'd5), 1'b0, 1'b0, -1);
  endtask

  task automatic test_random();
    int cur, d;
    logic [4:0] op;
    bit stp;
    cur = -1;
    for (int t = 0; t < 40; t++) begin
      d = int'($urandom_range(0, 1));
      if (d != cur) begin
        resync();
        cur = d;
      end
      op = 5'($urandom_range(0, 31));
      if (op == 5'd27) op = 5'd18;
      stp = ($urandom_range(0, 7) == 0);
      run_instr(d, mk(op), 1'($urandom), stp, -1);
    end
  endtask

  initial begin
    clr = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ir_s[i]   = NOP_IR;
      con_s[i]  = 1'b0;
      stop_s[i] = 1'b0;
    end
    test_reset();
    test_alu();
    test_imm_io();
    test_ld_st();
    test_br();
    test_clear_mid();
    test_stop();
    test_halt();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
